scratch_pad_stream_reader: RTL and testbench
============================================

# scratch_pad_stream_reader

Initiator for one scratch pad port: given a base address and length, issues sequential reads, honours the port's `full` backpressure, and returns the data as an in-order ready/valid stream. Credit-based accounting against a local response FIFO guarantees every returned word has a slot. One instance sits in front of each scratch pad port that needs bulk streaming reads.

## Interface
- `WIDTH`, 64, data word width
- `ADDR_WIDTH`, 15, scratch pad address width (64 ports × 512 words)
- `LEN_WIDTH`, 16, transfer length counter width
- `FIFO_DEPTH`, 16, response FIFO entries; power of two, ≥2

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: begin transfer; sampled only in IDLE
- `base_addr` in ADDR_WIDTH: first read address, latched on accepted start
- `length` in LEN_WIDTH: words to read, latched on accepted start
- `busy` out 1: high in ISSUE/DRAIN/DONE
- `done` out 1: one-cycle completion pulse
- `sp_rd_en` out 1: read request to scratch pad port
- `sp_addr` out ADDR_WIDTH: request address
- `sp_q` in WIDTH: scratch pad read data
- `sp_valid` in 1: `sp_q` valid this cycle
- `sp_full` in 1: port cannot accept a request this cycle
- `sp_stall` out 1: high when FIFO is full
- `out_data` out WIDTH: FIFO head
- `out_valid` out 1: FIFO non-empty
- `out_ready` in 1: consumer accepts `out_data`
- `protocol_err` out 1: sticky error flag

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `start`=1 with `length`≠0 → latch base/length, clear `protocol_err`, go ISSUE. `start`=1 with `length`=0 → go DONE directly. `start` is ignored outside IDLE.
- ISSUE: `sp_rd_en` = !`sp_full` && (`outstanding` + `fifo_count` < FIFO_DEPTH). This is combinational from registers plus `sp_full`. On each issue, `sp_addr` increments modulo 2^ADDR_WIDTH (the address wraps) and `remaining` decrements. The last issue moves the FSM to DRAIN.
- DRAIN: go DONE when `outstanding`=0 and the FIFO is empty (all data consumed).
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Counter `outstanding` (log2(FIFO_DEPTH)+1 bits): +1 on issue, −1 on `sp_valid`, unchanged when both occur.
- FIFO: push on `sp_valid`, pop on `out_valid`&&`out_ready`. Simultaneous push and pop leaves the count unchanged and is legal when full (pop frees the slot first).
- `sp_stall` = FIFO full (count = FIFO_DEPTH). Under correct credit operation the FIFO never overflows.
- `protocol_err` sets on either of two conditions:
  - `sp_valid` while `outstanding`=0; the data is discarded.
  - `sp_valid` while the FIFO is full and no pop occurs; the data is discarded.
  - `protocol_err` is sticky until reset or an accepted start.
- Responses return in issue order; no reordering is done here.

## Timing
- Reset values: state IDLE; `busy`, `done`, `sp_rd_en`, `sp_stall`, `out_valid`, `protocol_err` = 0; `sp_addr`, `out_data` = 0; all counters 0.
- Start accepted at edge 0 → ISSUE from cycle 1. The first `sp_rd_en` can be high in cycle 1 with `sp_addr`=`base_addr`.
- Peak rate is one request per cycle while `sp_full`=0 and credit remains.
- `sp_valid` at edge N → `out_valid` high in cycle N+1. With `out_ready` held high, the word pops at edge N+1.
- `done` is high in the cycle after the DRAIN exit condition holds; `busy` drops in the same cycle `done` falls.
- Reset asserted mid-transfer: all state clears immediately and asynchronously, and any FIFO data is lost. Late `sp_valid` after reset release sets `protocol_err`.

## Test plan
- length=1, base=5, memory[5]=0xAB → one `sp_rd_en` with `sp_addr`=5; `out_data`=0xAB; `done` pulses once; `busy` ends low.
- base=0, length=512, memory[i]=i, `out_ready`=1 → `out_data` sequence 0..511 in order, no gaps beyond scratch pad latency, `protocol_err`=0.
- length=64, `out_ready`=0 → exactly 16 requests issued, then `sp_rd_en` stays low. Raise `out_ready` → remaining 48 requests issue and all 64 words delivered.
- `sp_full` toggled randomly during length=100 → no request issued while `sp_full`=1; addresses are contiguous and none are skipped.
- base=32767, length=3 → `sp_addr` sequence 32767, 0, 1.
- length=0 start → `done` pulse the next cycle, no `sp_rd_en`. Then `sp_valid` injected in IDLE → `protocol_err`=1 until the next start.

Source files
------------

// File: rtl/scratch_pad_stream_reader.sv
// scratch_pad_stream_reader
// Streams a contiguous block of scratch pad words out as an in-order
// ready/valid stream. A read is issued only when the response FIFO is
// guaranteed to have a free slot for it: outstanding reads plus buffered
// words must stay below FIFO_DEPTH.
module scratch_pad_stream_reader #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,          // active-low, asynchronous
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  sp_rd_en,
  output logic [ADDR_WIDTH-1:0] sp_addr,
  input  logic [WIDTH-1:0]      sp_q,
  input  logic                  sp_valid,
  input  logic                  sp_full,
  output logic                  sp_stall,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  protocol_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
  logic [CW-1:0]         outstanding_reg, outstanding_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic                  err_reg, err_next;

  logic [WIDTH-1:0]      fifo_mem [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push;
  logic resp_expected;
  logic credit_ok;
  logic issue;
  logic err_set;

  // Datapath qualifiers derived from the registered counters.
  always_comb begin
    fifo_full     = (count_reg == CW'(FIFO_DEPTH));
    fifo_empty    = (count_reg == '0);
    pop           = !fifo_empty && out_ready;
    resp_expected = sp_valid && (outstanding_reg != '0);
    // A full FIFO can still take a word when the head leaves in the same cycle.
    push          = resp_expected && (!fifo_full || pop);
    err_set       = sp_valid && ((outstanding_reg == '0) || (fifo_full && !pop));
    credit_ok     = ({1'b0, outstanding_reg} + {1'b0, count_reg}) < (CW+1)'(FIFO_DEPTH);
    issue         = (state_reg == ISSUE) && !sp_full && credit_ok;
  end

  // Next-state, transfer counters and error flag.
  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    remaining_next   = remaining_reg;
    outstanding_next = outstanding_reg;
    count_next       = count_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    err_next         = err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          err_next = 1'b0;
          if (length != '0) begin
            addr_next      = base_addr;
            remaining_next = length;
            state_next     = ISSUE;
          end else begin
            state_next = DONE;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_next      = addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == LEN_WIDTH'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((outstanding_reg == '0) && fifo_empty) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Any response retires one outstanding read, even if it had to be dropped.
    case ({issue, resp_expected})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    // A violation in the same cycle as a start still gets reported.
    if (err_set) begin
      err_next = 1'b1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      remaining_reg   <= '0;
      outstanding_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      remaining_reg   <= remaining_next;
      outstanding_reg <= outstanding_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      err_reg         <= err_next;
    end
  end

  // Response storage; contents are meaningless whenever the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= sp_q;
    end
  end

  // Output mapping.
  always_comb begin
    busy         = (state_reg != IDLE);
    done         = (state_reg == DONE);
    sp_rd_en     = issue;
    sp_addr      = addr_reg;
    sp_stall     = fifo_full;
    out_valid    = !fifo_empty;
    out_data     = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    protocol_err = err_reg;
  end

endmodule

// File: tb/tb_scratch_pad_stream_reader.sv
// Testbench for scratch_pad_stream_reader: table of transfers against a
// scratch pad model with random in-order latency, plus hand-written
// sequences for zero length, spurious responses and mid-transfer reset.
module tb_scratch_pad_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] base_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic        sp_rd_en;
  logic [14:0] sp_addr;
  logic [63:0] sp_q;
  logic        sp_valid;
  logic        sp_full;
  logic        sp_stall;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] spmem [32768];

  typedef struct {
    int          base;
    int          len;
    int          full_pct;
    int          ready_pct;
    int          hold;       // out_ready forced low for cycles 1..hold
    int          exp_hold;   // requests expected by the end of the hold
    int          exp_last;   // last address expected on sp_addr
    logic [63:0] poke5;      // value placed at scratch pad word 5
  } vec_t;

  vec_t tbl[9];

  scratch_pad_stream_reader #(
    .WIDTH(64), .ADDR_WIDTH(15), .LEN_WIDTH(16), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .sp_rd_en(sp_rd_en),
    .sp_addr(sp_addr), .sp_q(sp_q), .sp_valid(sp_valid), .sp_full(sp_full),
    .sp_stall(sp_stall), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_transfer(input vec_t v, input int idx);
    logic [63:0] exp_q[$];
    logic [63:0] rdata_q[$];
    int          due_q[$];
    int          n_iss = 0;
    int          n_pop = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_pop = -1;
    int          last_due = 0;
    int          budget;
    int          due;
    int          err0;
    bit          finished = 0;
    logic [14:0] exp_addr;
    logic [14:0] last_addr;

    err0 = errors;
    spmem[5] = v.poke5;
    for (int i = 0; i < v.len; i++) exp_q.push_back(spmem[(v.base + i) % 32768]);
    exp_addr  = v.base[14:0];
    last_addr = '0;
    budget    = v.len * 20 + 200;

    @(negedge clk);
    base_addr = v.base[14:0];
    length    = v.len[15:0];
    start     = 1'b1;
    sp_full   = 1'b0;
    out_ready = 1'b0;
    sp_valid  = 1'b0;

    for (int c = 1; c <= budget && !finished; c++) begin
      @(negedge clk);
      start     = 1'b0;
      sp_full   = ($urandom_range(99) < v.full_pct);
      out_ready = (c <= v.hold) ? 1'b0 : ($urandom_range(99) < v.ready_pct);
      if (due_q.size() > 0 && due_q[0] <= c) begin
        void'(due_q.pop_front());
        sp_valid = 1'b1;
        sp_q     = rdata_q.pop_front();
      end else begin
        sp_valid = 1'b0;
        sp_q     = {$urandom, $urandom};
      end
      #1;
      if (c == 1) chk("err_cleared_on_start", protocol_err, 0);
      if (sp_rd_en) begin
        chk("no_issue_when_full", sp_full, 0);
        chk("issue_addr", sp_addr, exp_addr);
        chk("credit_limit", (n_iss - n_pop) < 16, 1);
        due = c + $urandom_range(1, 3);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        due_q.push_back(due);
        rdata_q.push_back(spmem[sp_addr]);
        last_addr = sp_addr;
        exp_addr  = exp_addr + 15'd1;
        n_iss++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else chk("out_data", out_data, exp_q.pop_front());
        n_pop++;
        last_pop = c;
      end
      if (c == v.hold) begin
        chk("hold_issues", n_iss, v.exp_hold);
        chk("hold_stall", sp_stall, 1);
        chk("hold_rd_en", sp_rd_en, 0);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        chk("busy_with_done", busy, 1);
      end else if (done_cyc >= 0) begin
        chk("busy_after_done", busy, 0);
        finished = 1;
      end
    end

    chk("completed_in_budget", finished, 1);
    chk("issued_count", n_iss, v.len);
    chk("delivered_count", n_pop, v.len);
    chk("done_pulses", done_cnt, 1);
    chk("last_addr", last_addr, v.exp_last);
    chk("done_timing", done_cyc, last_pop + 2);
    chk("protocol_err_clear", protocol_err, 0);
    $display("transfer %0d: base=%0d len=%0d issued=%0d delivered=%0d done_cycle=%0d errors=%0d",
             idx, v.base, v.len, n_iss, n_pop, done_cyc, errors - err0);
  endtask

  initial begin
    // Transfer table: base, len, full%, ready%, hold, exp_hold, exp_last, word5
    tbl[0] = '{5,     1,   0,  100, 0,  0,  5,     64'hAB};
    tbl[1] = '{0,     512, 0,  100, 0,  0,  511,   64'd5};
    tbl[2] = '{100,   64,  0,  100, 60, 16, 163,   64'd5};
    tbl[3] = '{200,   100, 50, 70,  0,  0,  299,   64'd5};
    tbl[4] = '{32767, 3,   0,  100, 0,  0,  1,     64'd5};
    tbl[5] = '{32700, 150, 30, 60,  0,  0,  81,    64'd5};
    tbl[6] = '{1000,  40,  20, 30,  0,  0,  1039,  64'd5};
    tbl[7] = '{7,     1,   0,  100, 0,  0,  7,     64'd5};
    tbl[8] = '{16384, 20,  40, 50,  0,  0,  16403, 64'd5};

    for (int i = 0; i < 32768; i++) spmem[i] = (i < 512) ? 64'(i) : {$urandom, $urandom};

    start = 0; base_addr = 0; length = 0; sp_q = 0; sp_valid = 0; sp_full = 0; out_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_en", sp_rd_en, 0);
    chk("reset_stall", sp_stall, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_err", protocol_err, 0);
    chk("reset_addr", sp_addr, 0);
    chk("reset_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: busy=%0b done=%0b sp_addr=%0d", busy, done, sp_addr);

    for (int i = 0; i < 7; i++) run_transfer(tbl[i], i);

    // Zero-length start, then a spurious response while idle.
    @(negedge clk);
    start = 1'b1; length = 16'd0; base_addr = 15'd0; out_ready = 1'b1; sp_full = 1'b0; sp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("zero_len_done", done, 1);
    chk("zero_len_busy", busy, 1);
    chk("zero_len_rd_en", sp_rd_en, 0);
    @(negedge clk);
    #1;
    chk("zero_len_done_fall", done, 0);
    chk("zero_len_busy_fall", busy, 0);
    chk("zero_len_rd_en_after", sp_rd_en, 0);
    @(negedge clk);
    sp_valid = 1'b1; sp_q = 64'hDEAD_BEEF;
    @(negedge clk);
    sp_valid = 1'b0;
    #1;
    chk("spurious_sets_err", protocol_err, 1);
    chk("spurious_discarded", out_valid, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("err_sticky", protocol_err, 1);
    $display("zero length: done pulse seen, protocol_err=%0b after spurious response", protocol_err);
    run_transfer(tbl[7], 7);

    // Reset asserted mid-transfer with data buffered and reads outstanding.
    @(negedge clk);
    start = 1'b1; base_addr = 15'h100; length = 16'd50; out_ready = 1'b0; sp_full = 1'b0; sp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("mid_first_rd_en", sp_rd_en, 1);
    chk("mid_first_addr", sp_addr, 15'h100);
    repeat (3) @(negedge clk);
    sp_valid = 1'b1; sp_q = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    sp_valid = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 1);
    chk("mid_out_data", out_data, 64'h1234_5678_9ABC_DEF0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_rd_en", sp_rd_en, 0);
    chk("async_addr", sp_addr, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_stall", sp_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sp_valid = 1'b1; sp_q = 64'h55;
    @(negedge clk);
    sp_valid = 1'b0;
    #1;
    chk("late_resp_err", protocol_err, 1);
    chk("late_resp_discarded", out_valid, 0);
    $display("mid-transfer reset: busy=%0b protocol_err=%0b after late response", busy, protocol_err);
    run_transfer(tbl[8], 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
